// File: rtl/byte_unit_pkg.sv
// Shared defaults and types for the bit -> byte -> bit relay unit.
package byte_unit_pkg;

    localparam int BYTE_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef logic [7:0] byte_t;

    // Serialiser phases: wait for a byte, offer one bit, enforce a dead cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with show-ahead read data and occupancy-based flags.
module byte_fifo
    import byte_unit_pkg::*;
#(
    parameter int WIDTH = BYTE_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at a power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/byte_unit.sv
// Relay between two single-bit semaphores: gathers LSB-first bits into bytes,
// buffers them, and replays them one strobed bit at a time downstream.
module byte_unit
    import byte_unit_pkg::*;
#(
    parameter int BYTE_W     = BYTE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic rstn,            // active-high synchronous reset despite the name
    input  logic sema_valid_i,
    input  logic sema_data_i,
    output logic sema_ready_o,
    input  logic sema_is_empty_i,
    output logic sema_write_o,
    output logic sema_data_o
);

    localparam int            IW   = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [IW-1:0] LAST = IW'(BYTE_W - 1);

    logic [IW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              accept;
    logic              push;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_rdata;

    tx_state_t         state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [BYTE_W-1:0] txreg_q, txreg_d;
    logic              write_q, write_d;
    logic              data_q, data_d;

    // Ready only depends on buffer space, never on valid, so no comb loop upstream.
    assign sema_ready_o = !fifo_full && !rstn;
    assign accept       = sema_valid_i && sema_ready_o;
    assign push         = accept && (bit_cnt_q == LAST);
    assign fifo_pop     = (state_q == IDLE) && !fifo_empty;
    assign sema_write_o = write_q;
    assign sema_data_o  = data_q;

    // Deserialiser: the pushed word is shreg_d, so the final bit lands in the same edge.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            shreg_d[bit_cnt_q] = sema_data_i;
            bit_cnt_d          = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + IW'(1);
        end
    end

    byte_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rstn),
        .push  (push),
        .pop   (fifo_pop),
        .wdata (shreg_d),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Serialiser: GAP forces a dead cycle so the downstream flag can fall after each write.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        txreg_d = txreg_q;
        write_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    txreg_d = fifo_rdata;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (sema_is_empty_i) begin
                    write_d = 1'b1;
                    data_d  = txreg_q[idx_q];
                    state_d = GAP;
                end
            end
            GAP: begin
                if (idx_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset drops any partial or in-flight byte.
    always_ff @(posedge clk) begin
        if (rstn) begin
            bit_cnt_q <= '0;
            state_q   <= IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            data_q    <= data_d;
        end
    end

    // Datapath registers; their contents are only consumed under control qualification.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        txreg_q <= txreg_d;
    end

endmodule

// File: tb/tb_byte_unit.sv
// Bench for byte_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_byte_unit;
    import byte_unit_pkg::*;

    localparam int DEPTH = FIFO_DEPTH_DEF;
    localparam int BOUND = 4000;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic sema_valid_i = 1'b0;
    logic sema_data_i = 1'b0;
    logic sema_is_empty_i = 1'b1;
    logic sema_ready_o;
    logic sema_write_o;
    logic sema_data_o;

    byte_unit dut (
        .clk             (clk),
        .rstn            (rstn),
        .sema_valid_i    (sema_valid_i),
        .sema_data_i     (sema_data_i),
        .sema_ready_o    (sema_ready_o),
        .sema_is_empty_i (sema_is_empty_i),
        .sema_write_o    (sema_write_o),
        .sema_data_o     (sema_data_o)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   seen_rst = 1'b0;
    bit   rnd_mode = 1'b0;
    bit   gaps = 1'b0;
    logic out_log[$];
    int   w_cyc[$];

    // Reference model: bits being gathered, buffered bytes, bits left in the byte on air.
    logic  m_in[$];
    byte_t m_fifo[$];
    logic  m_tx[$];
    bit    m_active = 1'b0;
    bit    m_gap = 1'b0;
    logic  m_write = 1'b0;
    logic  m_data = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic byte_t log_byte(input int base);
        byte_t b;
        for (int i = 0; i < 8; i++)
            b[i] = (base + i < out_log.size()) ? out_log[base + i] : 1'bx;
        return b;
    endfunction

    // Model advance and per-cycle comparison.
    initial begin
        logic  r, v, d, e;
        bit    pre_rdy, acc;
        logic  prev_w;
        byte_t b;
        prev_w = 1'b0;
        forever begin
            @(posedge clk);
            r = rstn; v = sema_valid_i; d = sema_data_i; e = sema_is_empty_i;
            pre_rdy = !r && (m_fifo.size() < DEPTH);
            cyc++;
            if (r) begin
                m_in.delete(); m_fifo.delete(); m_tx.delete();
                m_active = 1'b0; m_gap = 1'b0; m_write = 1'b0; m_data = 1'b0;
                seen_rst = 1'b1;
            end else begin
                acc = v && pre_rdy;
                if (!m_active) begin
                    m_write = 1'b0;
                    if (m_fifo.size() > 0) begin
                        b = m_fifo.pop_front();
                        m_tx.delete();
                        for (int i = 0; i < 8; i++) m_tx.push_back(b[i]);
                        m_active = 1'b1;
                    end
                end else if (m_gap) begin
                    m_gap = 1'b0;
                    m_write = 1'b0;
                    if (m_tx.size() == 0) m_active = 1'b0;
                end else if (e) begin
                    m_write = 1'b1;
                    m_data = m_tx.pop_front();
                    m_gap = 1'b1;
                end else begin
                    m_write = 1'b0;
                end
                if (acc) begin
                    m_in.push_back(d);
                    if (m_in.size() == 8) begin
                        for (int i = 0; i < 8; i++) b[i] = m_in[i];
                        m_fifo.push_back(b);
                        m_in.delete();
                    end
                end
            end
            #1;
            if (seen_rst) begin
                chk("write_o", 32'(sema_write_o), 32'(m_write));
                chk("data_o", 32'(sema_data_o), 32'(m_data));
                chk("ready_o", 32'(sema_ready_o), 32'(!rstn && (m_fifo.size() < DEPTH)));
                chk("strobe_gap", 32'(sema_write_o && prev_w), 32'd0);
                prev_w = sema_write_o;
                if (sema_write_o === 1'b1) begin
                    out_log.push_back(sema_data_o);
                    w_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic send_bit(input logic b, output int acc_at);
        acc_at = -1;
        for (int t = 0; t < BOUND; t++) begin
            @(negedge clk);
            if (rnd_mode) sema_is_empty_i = ($urandom_range(0, 3) != 0);
            if (gaps && $urandom_range(0, 2) == 0) begin
                sema_valid_i = 1'b0;
                sema_data_i  = 1'($urandom);
            end else begin
                sema_valid_i = 1'b1;
                sema_data_i  = b;
                if (sema_ready_o === 1'b1) begin
                    acc_at = cyc + 1;
                    return;
                end
            end
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_byte(input byte_t v, output int acc_at);
        for (int i = 0; i < 8; i++) send_bit(v[i], acc_at);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sema_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < BOUND; t++) begin
            @(negedge clk);
            sema_valid_i = 1'b0;
            sema_is_empty_i = 1'b1;
            if (m_fifo.size() == 0 && !m_active) begin
                idle(3);
                return;
            end
        end
        chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_log(input int n);
        for (int t = 0; t < BOUND; t++) begin
            @(negedge clk);
            sema_valid_i = 1'b0;
            if (out_log.size() >= n) return;
        end
        chk("output_timeout", 32'(out_log.size()), 32'(n));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int    acc, base, n_at;
        byte_t bt;
        byte_t bp[5];
        byte_t sent[$];
        bp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h80};

        // Reset held for two edges with valid asserted
        rstn = 1'b1; sema_valid_i = 1'b1; sema_is_empty_i = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(sema_ready_o), 32'd0);
        chk("rst_write", 32'(sema_write_o), 32'd0);
        chk("rst_data", 32'(sema_data_o), 32'd0);
        rstn = 1'b0; sema_valid_i = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(sema_ready_o), 32'd1);

        // Single byte 0xA5
        base = out_log.size();
        send_byte(8'hA5, acc);
        drain();
        chk("a5_count", 32'(out_log.size() - base), 32'd8);
        chk("a5_data", 32'(log_byte(base)), 32'h0000_00A5);
        chk("a5_latency", 32'(w_cyc[base] - acc), 32'd2);

        // Back-pressure with the downstream stalled
        base = out_log.size();
        sema_is_empty_i = 1'b0;
        for (int k = 0; k < 5; k++) send_byte(bp[k], acc);
        idle(3);
        chk("bp_ready_low", 32'(sema_ready_o), 32'd0);
        chk("bp_no_writes", 32'(out_log.size() - base), 32'd0);
        drain();
        chk("bp_count", 32'(out_log.size() - base), 32'd40);
        for (int k = 0; k < 5; k++) chk("bp_byte", 32'(log_byte(base + 8 * k)), 32'(bp[k]));
        chk("bp_ready_back", 32'(sema_ready_o), 32'd1);

        // Downstream stall after three output bits
        base = out_log.size();
        bt = byte_t'($urandom);
        send_byte(bt, acc);
        wait_log(base + 3);
        sema_is_empty_i = 1'b0;
        idle(5);
        chk("stall_hold", 32'(out_log.size() - base), 32'd3);
        drain();
        chk("stall_data", 32'(log_byte(base)), 32'(bt));

        // Valid gaps while sending 0x3C
        base = out_log.size();
        gaps = 1'b1;
        send_byte(8'h3C, acc);
        gaps = 1'b0;
        drain();
        chk("gaps_data", 32'(log_byte(base)), 32'h0000_003C);
        chk("gaps_count", 32'(out_log.size() - base), 32'd8);

        // Reset after four input bits and two output bits
        base = out_log.size();
        send_byte(8'h96, acc);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), acc);
        wait_log(base + 2);
        rstn = 1'b1;
        idle(2);
        rstn = 1'b0;
        n_at = out_log.size();
        chk("rst_mid_bits", 32'(n_at - base), 32'd2);
        chk("rst_mid_b0", 32'(out_log[base]), 32'd0);
        chk("rst_mid_b1", 32'(out_log[base + 1]), 32'd1);
        idle(20);
        chk("rst_no_writes", 32'(out_log.size() - n_at), 32'd0);
        base = out_log.size();
        send_byte(8'hFF, acc);
        drain();
        chk("ff_count", 32'(out_log.size() - base), 32'd8);
        chk("ff_data", 32'(log_byte(base)), 32'h0000_00FF);

        // Random traffic with random downstream stalls and valid gaps
        base = out_log.size();
        rnd_mode = 1'b1; gaps = 1'b1;
        for (int k = 0; k < 24; k++) begin
            bt = byte_t'($urandom);
            sent.push_back(bt);
            send_byte(bt, acc);
        end
        rnd_mode = 1'b0; gaps = 1'b0;
        drain();
        chk("rand_count", 32'(out_log.size() - base), 32'(8 * sent.size()));
        for (int k = 0; k < sent.size(); k++)
            chk("rand_byte", 32'(log_byte(base + 8 * k)), 32'(sent[k]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
